// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for one shared memory port.
// Requester 0 is instruction fetch, requester 1 is data access.
module mem_port_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned TIMEOUT    = 16,
    parameter bit          FIRST_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    output logic          req1_ready,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic          mem_req,
    output logic          mem_sel,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          timeout_err
);

    localparam int unsigned CW   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned TLIM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TLIM);
    localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t        r_state, w_state;
    logic          r_mem_req, w_mem_req;
    logic          r_mem_sel, w_mem_sel;
    logic [AW-1:0] r_mem_addr, w_mem_addr;
    logic          r_ready0, w_ready0;
    logic          r_ready1, w_ready1;
    logic [DW-1:0] r_rdata, w_rdata;
    logic          r_err, w_err;
    logic          r_terr, w_terr;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_last, w_last;
    logic          w_win;

    // Ties go to whoever did not win last; a lone requester always wins
    assign w_win = (req0_valid && req1_valid) ? ~r_last : req1_valid;

    always_comb begin
        w_state    = r_state;
        w_mem_req  = r_mem_req;
        w_mem_sel  = r_mem_sel;
        w_mem_addr = r_mem_addr;
        w_ready0   = 1'b0;
        w_ready1   = 1'b0;
        w_rdata    = r_rdata;
        w_err      = r_err;
        w_terr     = r_terr;
        w_cnt      = r_cnt;
        w_last     = r_last;
        unique case (r_state)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    w_state    = S_BUSY;
                    w_mem_req  = 1'b1;
                    w_mem_sel  = w_win;
                    w_mem_addr = w_win ? req1_addr : req0_addr;
                    w_last     = w_win;
                    w_cnt      = '0;
                end
            end
            S_BUSY: begin
                if (mem_ack) begin
                    w_state   = S_RESP;
                    w_mem_req = 1'b0;
                    w_rdata   = mem_rdata;
                    w_err     = 1'b0;
                    w_ready0  = ~r_mem_sel;
                    w_ready1  = r_mem_sel;
                end else if (TIMEOUT != 0 && r_cnt == CNT_LAST) begin
                    w_state   = S_RESP;
                    w_mem_req = 1'b0;
                    w_rdata   = '0;
                    w_err     = 1'b1;
                    w_terr    = 1'b1;
                    w_ready0  = ~r_mem_sel;
                    w_ready1  = r_mem_sel;
                end else if (r_cnt != CNT_SAT) begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_RESP: begin
                w_state = S_IDLE;
                w_rdata = '0;
                w_err   = 1'b0;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_sel  <= 1'b0;
            r_mem_addr <= '0;
            r_ready0   <= 1'b0;
            r_ready1   <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_terr     <= 1'b0;
            r_cnt      <= '0;
            r_last     <= ~FIRST_PRIO;
        end else begin
            r_state    <= w_state;
            r_mem_req  <= w_mem_req;
            r_mem_sel  <= w_mem_sel;
            r_mem_addr <= w_mem_addr;
            r_ready0   <= w_ready0;
            r_ready1   <= w_ready1;
            r_rdata    <= w_rdata;
            r_err      <= w_err;
            r_terr     <= w_terr;
            r_cnt      <= w_cnt;
            r_last     <= w_last;
        end
    end

    assign req0_ready  = r_ready0;
    assign req1_ready  = r_ready1;
    assign resp_rdata  = r_rdata;
    assign resp_err    = r_err;
    assign mem_req     = r_mem_req;
    assign mem_sel     = r_mem_sel;
    assign mem_addr    = r_mem_addr;
    assign timeout_err = r_terr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter (TIMEOUT=4, FIRST_PRIO=0).
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        req;
        logic        sel;
        logic [31:0] addr;
        logic        r0;
        logic        r1;
        logic [31:0] rd;
        logic        err;
        logic        terr;
    } out_t;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        ack;
        logic [31:0] rd;
        out_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic [31:0] req0_addr = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [31:0] req1_addr = '0;
    logic        req1_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_sel;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        timeout_err;

    int n_pass = 0;
    int n_tot  = 0;

    mem_port_arbiter #(
        .AW(32), .DW(32), .TIMEOUT(4), .FIRST_PRIO(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr),
        .req1_ready(req1_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic out_t O(input logic req, input logic sel,
                               input logic [31:0] addr, input logic r0,
                               input logic r1, input logic [31:0] rd,
                               input logic err, input logic terr);
        out_t o;
        o = '{req, sel, addr, r0, r1, rd, err, terr};
        return o;
    endfunction

    function automatic vec_t V(input logic v0, input logic v1,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic ack, input logic [31:0] rd,
                               input out_t e);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.a0 = a0; v.a1 = a1;
        v.ack = ack; v.rd = rd; v.e = e;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input out_t e);
        out_t a;
        a = O(mem_req, mem_sel, mem_addr, req0_ready, req1_ready,
              resp_rdata, resp_err, timeout_err);
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got req=%0b sel=%0b addr=%h r0=%0b r1=%0b rd=%h err=%0b terr=%0b want req=%0b sel=%0b addr=%h r0=%0b r1=%0b rd=%h err=%0b terr=%0b",
                      nm, a.req, a.sel, a.addr, a.r0, a.r1, a.rd, a.err, a.terr,
                      e.req, e.sel, e.addr, e.r0, e.r1, e.rd, e.err, e.terr);
    endtask

    task automatic drive(input logic v0, input logic v1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic ack, input logic [31:0] rd);
        req0_valid = v0; req1_valid = v1;
        req0_addr = a0; req1_addr = a1;
        mem_ack = ack; mem_rdata = rd;
    endtask

    initial begin
        vec_t vt[22];
        out_t z;
        z = O(0, 0, 0, 0, 0, 0, 0, 0);

        // Alternating grants, then single fetch, stray ack, address change in BUSY
        vt[0]  = V(1, 1, 32'h100, 32'h200, 0, 0,        O(1, 0, 32'h100, 0, 0, 0, 0, 0));
        vt[1]  = V(1, 1, 32'h100, 32'h200, 1, 32'hA0,   O(0, 0, 32'h100, 1, 0, 32'hA0, 0, 0));
        vt[2]  = V(1, 1, 32'h100, 32'h200, 0, 0,        O(0, 0, 32'h100, 0, 0, 0, 0, 0));
        vt[3]  = V(1, 1, 32'h100, 32'h200, 0, 0,        O(1, 1, 32'h200, 0, 0, 0, 0, 0));
        vt[4]  = V(1, 1, 32'h100, 32'h200, 1, 32'hB1,   O(0, 1, 32'h200, 0, 1, 32'hB1, 0, 0));
        vt[5]  = V(1, 1, 32'h100, 32'h200, 0, 0,        O(0, 1, 32'h200, 0, 0, 0, 0, 0));
        vt[6]  = V(1, 1, 32'h100, 32'h200, 0, 0,        O(1, 0, 32'h100, 0, 0, 0, 0, 0));
        vt[7]  = V(1, 1, 32'h100, 32'h200, 1, 32'hC2,   O(0, 0, 32'h100, 1, 0, 32'hC2, 0, 0));
        vt[8]  = V(1, 1, 32'h100, 32'h200, 0, 0,        O(0, 0, 32'h100, 0, 0, 0, 0, 0));
        vt[9]  = V(1, 1, 32'h100, 32'h200, 0, 0,        O(1, 1, 32'h200, 0, 0, 0, 0, 0));
        vt[10] = V(1, 1, 32'h100, 32'h200, 1, 32'hD3,   O(0, 1, 32'h200, 0, 1, 32'hD3, 0, 0));
        vt[11] = V(0, 0, 32'h100, 32'h200, 0, 0,        O(0, 1, 32'h200, 0, 0, 0, 0, 0));
        vt[12] = V(1, 0, 32'h40, 0, 0, 0,               O(1, 0, 32'h40, 0, 0, 0, 0, 0));
        vt[13] = V(1, 0, 32'h40, 0, 0, 0,               O(1, 0, 32'h40, 0, 0, 0, 0, 0));
        vt[14] = V(1, 0, 32'h40, 0, 1, 32'h1234_5678,   O(0, 0, 32'h40, 1, 0, 32'h1234_5678, 0, 0));
        vt[15] = V(0, 0, 32'h40, 0, 0, 0,               O(0, 0, 32'h40, 0, 0, 0, 0, 0));
        vt[16] = V(0, 0, 32'h40, 0, 1, 32'hDEAD,        O(0, 0, 32'h40, 0, 0, 0, 0, 0));
        vt[17] = V(0, 1, 0, 32'h300, 0, 0,              O(1, 1, 32'h300, 0, 0, 0, 0, 0));
        vt[18] = V(0, 1, 0, 32'h3FC, 0, 0,              O(1, 1, 32'h300, 0, 0, 0, 0, 0));
        vt[19] = V(0, 1, 0, 32'h3FC, 1, 32'h55,         O(0, 1, 32'h300, 0, 1, 32'h55, 0, 0));
        vt[20] = V(0, 0, 0, 32'h3FC, 0, 0,              O(0, 1, 32'h300, 0, 0, 0, 0, 0));
        vt[21] = V(0, 0, 0, 0, 1, 32'hBEEF,             O(0, 1, 32'h300, 0, 0, 0, 0, 0));

        repeat (3) tick();
        chk("reset", z);
        rst_n = 1'b1;
        tick();
        chk("idle_after_reset", z);

        for (int i = 0; i < 22; i++) begin
            drive(vt[i].v0, vt[i].v1, vt[i].a0, vt[i].a1, vt[i].ack, vt[i].rd);
            tick();
            chk($sformatf("vec%0d", i), vt[i].e);
        end

        // Watchdog abort on requester 1 after 4 BUSY cycles
        drive(0, 1, 0, 32'h600, 0, 0);
        tick();
        chk("to_grant", O(1, 1, 32'h600, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("to_busy%0d", i), O(1, 1, 32'h600, 0, 0, 0, 0, 0));
        end
        tick();
        chk("to_abort", O(0, 1, 32'h600, 0, 1, 0, 1, 1));
        drive(0, 0, 0, 32'h600, 0, 0);
        tick();
        chk("to_idle_sticky", O(0, 1, 32'h600, 0, 0, 0, 0, 1));

        // Ack coinciding with watchdog expiry completes normally
        drive(1, 0, 32'h700, 0, 0, 0);
        tick();
        chk("co_grant", O(1, 0, 32'h700, 0, 0, 0, 0, 1));
        repeat (3) tick();
        chk("co_busy", O(1, 0, 32'h700, 0, 0, 0, 0, 1));
        drive(1, 0, 32'h700, 0, 1, 32'h77);
        tick();
        chk("co_resp", O(0, 0, 32'h700, 1, 0, 32'h77, 0, 1));
        drive(0, 0, 32'h700, 0, 0, 0);
        tick();
        chk("co_idle", O(0, 0, 32'h700, 0, 0, 0, 0, 1));

        // Reset mid-BUSY; afterwards a tie must go to requester 0
        drive(1, 0, 32'h800, 0, 0, 0);
        tick();
        chk("rs_grant", O(1, 0, 32'h800, 0, 0, 0, 0, 1));
        tick();
        drive(1, 1, 32'h800, 32'h900, 1, 32'h99);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_async", z);
        tick();
        chk("rs_held", z);
        rst_n = 1'b1;
        mem_ack = 1'b0;
        tick();
        chk("rs_tie_prio", O(1, 0, 32'h800, 0, 0, 0, 0, 0));
        mem_ack = 1'b1;
        mem_rdata = 32'h88;
        tick();
        chk("rs_resp", O(0, 0, 32'h800, 1, 0, 32'h88, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
